// File: rtl/div_sequencer.sv
// Operand feeder/result collector for a 32-cycle restoring divider; result valid 36 cycles after accept (2 for divide-by-zero).
// Backpressure: in_ready drops while the 2-entry operand buffer is full; a result waits in DONE until out_ready.
module div_sequencer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dbz,
    output logic             busy
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_mem_a [DEPTH];
    logic [WIDTH-1:0]  r_mem_b [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [WIDTH-1:0]  r_op_a;
    logic [WIDTH-1:0]  r_op_b;
    logic [CNTW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_out_q;
    logic [WIDTH-1:0]  r_out_r;
    logic              r_out_dbz;

    logic              w_push;
    logic              w_pop;
    logic              w_load_dbz;
    logic              w_load_div;
    logic [WIDTH-1:0]  w_head_a;
    logic [WIDTH-1:0]  w_head_b;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign w_push    = in_valid & in_ready;
    assign w_head_a  = r_mem_a[r_rd_ptr];
    assign w_head_b  = r_mem_b[r_rd_ptr];

    assign div_start = (r_state == S_START);
    assign div_a     = r_op_a;
    assign div_b     = r_op_b;
    assign out_valid = (r_state == S_DONE);
    assign out_q     = r_out_q;
    assign out_r     = r_out_r;
    assign out_dbz   = r_out_dbz;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_dbz  = 1'b0;
        w_load_div  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if (w_head_b == '0) begin
                        w_load_dbz  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: w_state_nxt = S_RUN;
            S_RUN: begin
                if (r_cnt == CNTW'(WIDTH - 1)) begin
                    w_state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                w_load_div  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pointers wrap naturally because the buffer depth is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr] <= in_a;
                r_mem_b[r_wr_ptr] <= in_b;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Divider operands stay frozen from pop until the next pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_op_a <= w_head_a;
                r_op_b <= w_head_b;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_q   <= '0;
            r_out_r   <= '0;
            r_out_dbz <= 1'b0;
        end else if (w_load_dbz) begin
            r_out_q   <= '1;
            r_out_r   <= w_head_a;
            r_out_dbz <= 1'b1;
        end else if (w_load_div) begin
            r_out_q   <= div_q;
            r_out_r   <= div_r;
            r_out_dbz <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a cycle-accurate restoring divider model on the div_* side.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic [31:0] out_r;
    logic        out_dbz;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    div_sequencer #(.DEPTH(2), .WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dbz   (out_dbz),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Restoring divider: dividend captured on start, divisor read live each step.
    logic [31:0] m_quo = '0;
    logic [31:0] m_rem = '0;
    int          m_left = 0;
    logic [32:0] m_tmp;
    assign div_q = m_quo;
    assign div_r = m_rem;
    always @(posedge clock) begin
        if (div_start) begin
            m_rem  <= '0;
            m_quo  <= div_a;
            m_left <= 32;
        end else if (m_left != 0) begin
            m_tmp = {m_rem, m_quo[31]};
            if (m_tmp >= {1'b0, div_b}) begin
                m_rem <= m_tmp[31:0] - div_b;
                m_quo <= {m_quo[30:0], 1'b1};
            end else begin
                m_rem <= m_tmp[31:0];
                m_quo <= {m_quo[30:0], 1'b0};
            end
            m_left <= m_left - 1;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [64:0] mon_prev = '0;
    logic        mon_hold = 1'b0;
    always @(negedge clock) begin
        #2;
        if (reset_n === 1'b1) begin
            if (out_valid) chk("start_in_done", div_start, 0);
            if (mon_hold) chk("out_stable", {out_q, out_r, out_dbz}, mon_prev);
        end
        mon_hold = (reset_n === 1'b1) & out_valid & ~out_ready;
        mon_prev = {out_q, out_r, out_dbz};
    end

    task automatic run_job(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                           input int elat);
        int          first;
        int          starts;
        logic [64:0] res;
        first  = 0;
        starts = 0;
        res    = '0;
        @(negedge clock);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clock);
        in_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clock);
            if (div_start) starts++;
            if (out_valid) begin
                first = c;
                res   = {out_q, out_r, out_dbz};
                break;
            end
        end
        chk({tag, "_latency"}, first, elat);
        chk({tag, "_starts"}, starts, (b == 0) ? 0 : 1);
        chk({tag, "_result"}, res, {eq, er, edbz});
        @(negedge clock);
        chk({tag, "_valid_drop"}, out_valid, 0);
    endtask

    logic [31:0] exp_q [4];
    logic [31:0] exp_r [4];
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    logic [31:0] ea, eb, rb;
    int          idx, sent, got, first;
    logic        acc;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_ab", {div_a, div_b}, 0);
        chk("rst_out", {out_valid, out_q, out_r, out_dbz}, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;

        run_job("j100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 36);
        run_job("jmax_1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 36);
        run_job("j5_max", 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 1'b0, 36);
        run_job("jdbz", 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 2);

        // Three back-to-back pushes with the consumer stalled, plus a fourth that must wait.
        out_ready = 1'b0;
        @(negedge clock); in_valid = 1'b1; in_a = 32'd100; in_b = 32'd7;
        @(negedge clock); in_a = 32'd9;  in_b = 32'd3;
        @(negedge clock); in_a = 32'd17; in_b = 32'd5;
        @(negedge clock); in_a = 32'd50; in_b = 32'd6;
        chk("full_in_ready", in_ready, 0);
        chk("full_busy", busy, 1);
        first = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                first = 1;
                break;
            end
            @(negedge clock);
        end
        chk("stall_valid", first, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_result", {out_q, out_r, out_dbz}, {32'd14, 32'd2, 1'b0});
        repeat (5) @(negedge clock);
        chk("stall_held", {out_valid, in_ready}, 2'b10);

        exp_q[1] = 32'd3; exp_r[1] = 32'd0;
        exp_q[2] = 32'd3; exp_r[2] = 32'd2;
        exp_q[3] = 32'd8; exp_r[3] = 32'd2;
        out_ready = 1'b1;
        idx = 1;
        acc = 1'b0;
        for (int c = 0; c < 400 && idx < 4; c++) begin
            @(negedge clock);
            if (acc) begin
                in_valid = 1'b0;
                acc      = 1'b0;
            end
            if (out_valid) begin
                chk("order_result", {out_q, out_r, out_dbz}, {exp_q[idx], exp_r[idx], 1'b0});
                idx++;
            end
            if (in_valid && in_ready) acc = 1'b1;
        end
        chk("order_count", idx, 4);
        @(negedge clock);
        chk("order_idle", {out_valid, busy, in_valid}, 0);

        // Async reset in the 20th RUN cycle (cycle 22 after the accept edge).
        @(negedge clock); in_valid = 1'b1; in_a = 32'd100; in_b = 32'd7;
        @(negedge clock); in_valid = 1'b0;
        repeat (21) @(negedge clock);
        chk("pre_rst_busy", {busy, div_start, out_valid}, 3'b100);
        reset_n = 1'b0;
        #1;
        chk("arst_div", {div_start, div_a, div_b}, 0);
        chk("arst_out", {out_valid, out_q, out_r, out_dbz}, 0);
        chk("arst_flow", {in_ready, busy}, 2'b10);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run_job("post_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 36);

        // Random jobs with a randomly stalling consumer.
        sent = 0;
        got  = 0;
        acc  = 1'b0;
        for (int c = 0; c < 20000 && got < 50; c++) begin
            @(negedge clock);
            if (acc) begin
                q_a.push_back(in_a);
                q_b.push_back(in_b);
                in_valid = 1'b0;
                acc      = 1'b0;
                sent++;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (q_a.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    ea = q_a.pop_front();
                    eb = q_b.pop_front();
                    if (eb == 0) chk("rnd_dbz", {out_q, out_r, out_dbz}, {32'hFFFFFFFF, ea, 1'b1});
                    else         chk("rnd_div", {out_q, out_r, out_dbz}, {ea / eb, ea % eb, 1'b0});
                end
                got++;
            end
            if (!in_valid && sent < 50 && $urandom_range(0, 3) == 0) begin
                rb = $urandom_range(0, 7);
                in_a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1000) : $urandom;
                if (rb == 0)      in_b = 32'd0;
                else if (rb < 4)  in_b = $urandom_range(1, 20);
                else              in_b = $urandom | 32'd1;
                in_valid = 1'b1;
            end
            if (in_valid && in_ready) acc = 1'b1;
        end
        chk("rnd_count", got, 50);
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
